// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined sweep ALU.
// Op encoding, flag bit positions and controller states.
package alu_pkg;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_XOR  = 3'd2;
   localparam logic [2:0] OP_AND  = 3'd3;
   localparam logic [2:0] OP_OR   = 3'd4;
   localparam logic [2:0] OP_XNOR = 3'd5;
   localparam logic [2:0] OP_NAND = 3'd6;
   localparam logic [2:0] OP_NOR  = 3'd7;

   localparam int FLG_ZERO  = 0;
   localparam int FLG_NEG   = 1;
   localparam int FLG_CARRY = 2;
   localparam int FLG_OVF   = 3;

   typedef enum logic [1:0] {
      IDLE,
      SWEEP,
      DRAIN
   } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: {op,a,b} -> {result,flags}.
// Carry doubles as borrow for SUB.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] dif;
   logic           carry;
   logic           ovf;

   assign sum = {1'b0, a} + {1'b0, b};
   assign dif = {1'b0, a} - {1'b0, b};

   always_comb begin
      result = '0;
      carry  = 1'b0;
      ovf    = 1'b0;
      case (op)
         OP_ADD: begin
            result = sum[WIDTH-1:0];
            carry  = sum[WIDTH];
            ovf    = (a[WIDTH-1] == b[WIDTH-1]) &&
                     (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            result = dif[WIDTH-1:0];
            carry  = dif[WIDTH];
            ovf    = (a[WIDTH-1] != b[WIDTH-1]) &&
                     (dif[WIDTH-1] != a[WIDTH-1]);
         end
         OP_XOR:  result = a ^ b;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XNOR: result = ~(a ^ b);
         OP_NAND: result = ~(a & b);
         OP_NOR:  result = ~(a | b);
         default: result = '0;
      endcase
   end

   always_comb begin
      flags            = '0;
      flags[FLG_ZERO]  = (result == '0);
      flags[FLG_NEG]   = result[WIDTH-1];
      flags[FLG_CARRY] = carry;
      flags[FLG_OVF]   = ovf;
   end

endmodule

// File: rtl/alu_pipe_sweep.sv
// Two-stage ALU pipeline with valid/ready on both sides and
// an internal a=b=i sweep source sharing the same pipeline.
module alu_pipe_sweep
   import alu_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int SWEEP_LEN = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sweep_start,
   input  logic [2:0]       sweep_op,
   output logic             busy,
   output logic             sweep_done,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   localparam int CW = $clog2(SWEEP_LEN + 1);

   state_t           state;
   state_t           state_nx;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nx;
   logic [2:0]       sop;
   logic [2:0]       sop_nx;

   logic             s1_v;
   logic [2:0]       s1_op;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic             s2_v;
   logic [WIDTH-1:0] s2_r;
   logic [3:0]       s2_f;

   logic             stall;
   logic             take;
   logic             issue;
   logic [2:0]       mux_op;
   logic [WIDTH-1:0] mux_a;
   logic [WIDTH-1:0] mux_b;
   logic [WIDTH-1:0] core_r;
   logic [3:0]       core_f;

   assign stall    = s2_v & ~out_ready;
   assign in_ready = (state == IDLE) & ~sweep_start & ~stall & ~rst;
   assign take     = in_valid & in_ready;
   assign issue    = (state == SWEEP) & ~stall;

   // Sweep operands wrap to WIDTH bits when SWEEP_LEN > 2^WIDTH
   assign mux_op = issue ? sop : op;
   assign mux_a  = issue ? WIDTH'(cnt) : a;
   assign mux_b  = issue ? WIDTH'(cnt) : b;

   assign busy      = (state != IDLE);
   assign out_valid = s2_v;
   assign result    = s2_r;
   assign flags     = s2_f;

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      sop_nx     = sop;
      sweep_done = 1'b0;
      case (state)
         IDLE: begin
            if (sweep_start) begin
               state_nx = SWEEP;
               cnt_nx   = '0;
               sop_nx   = sweep_op;
            end
         end
         SWEEP: begin
            if (!stall) begin
               cnt_nx = cnt + 1'b1;
               if (cnt == CW'(SWEEP_LEN - 1))
                  state_nx = DRAIN;
            end
         end
         DRAIN: begin
            // Both stages empty means the last result was taken
            if (!s1_v && !s2_v) begin
               sweep_done = 1'b1;
               state_nx   = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   alu_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .op     (s1_op),
      .a      (s1_a),
      .b      (s1_b),
      .result (core_r),
      .flags  (core_f)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         sop   <= '0;
         s1_v  <= 1'b0;
         s1_op <= '0;
         s1_a  <= '0;
         s1_b  <= '0;
         s2_v  <= 1'b0;
         s2_r  <= '0;
         s2_f  <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         sop   <= sop_nx;
         if (!stall) begin
            s1_v  <= take | issue;
            s1_op <= mux_op;
            s1_a  <= mux_a;
            s1_b  <= mux_b;
            s2_v  <= s1_v;
            s2_r  <= core_r;
            s2_f  <= core_f;
         end
      end
   end

endmodule

// File: tb/tb_alu_pipe_sweep.sv
// Bench for alu_pipe_sweep: directed corner cases plus a
// randomized phase checked against a queue-based result model.
module tb_alu_pipe_sweep;

   localparam int W  = 8;
   localparam int SL = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [2:0]   op = '0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         sweep_start = 1'b0;
   logic [2:0]   sweep_op = '0;
   logic         busy;
   logic         sweep_done;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] result;
   logic [3:0]   flags;

   always #5 clk = ~clk;

   alu_pipe_sweep #(
      .WIDTH     (W),
      .SWEEP_LEN (SL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .op          (op),
      .a           (a),
      .b           (b),
      .sweep_start (sweep_start),
      .sweep_op    (sweep_op),
      .busy        (busy),
      .sweep_done  (sweep_done),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .flags       (flags)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0] r;
      logic [3:0] f;
      bit         last;
   } exp_t;

   exp_t q[$];
   bit   mbusy = 0;
   bit   pend_done = 0;
   bit   prev_stall = 0;
   logic [7:0] prev_r;
   logic [3:0] prev_f;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(logic [2:0] o, logic [7:0] x, logic [7:0] y);
      int   ux, uy, sx, sy, r, s;
      bit   c, v;
      exp_t e;
      ux = int'(x);
      uy = int'(y);
      sx = (ux >= 128) ? ux - 256 : ux;
      sy = (uy >= 128) ? uy - 256 : uy;
      r = 0; s = 0; c = 0; v = 0;
      case (o)
         3'd0: begin
            r = ux + uy; c = (r > 255);
            s = sx + sy; v = (s > 127) || (s < -128);
         end
         3'd1: begin
            r = ux - uy; c = (ux < uy);
            s = sx - sy; v = (s > 127) || (s < -128);
         end
         3'd2: r = ux ^ uy;
         3'd3: r = ux & uy;
         3'd4: r = ux | uy;
         3'd5: r = ~(ux ^ uy);
         3'd6: r = ~(ux & uy);
         default: r = ~(ux | uy);
      endcase
      e.r = 8'(r & 255);
      e.f = {v, c, (e.r >= 8'd128), (e.r == 8'd0)};
      e.last = 0;
      return e;
   endfunction

   // Scoreboard: handshakes observed at negedge, settle on next posedge
   always @(negedge clk) begin
      exp_t e;
      bit   dn;
      if (rst) begin
         q.delete();
         mbusy = 0;
         pend_done = 0;
         prev_stall = 0;
      end else begin
         dn = pend_done;
         pend_done = 0;
         chk("done", sweep_done, dn);
         chk("busy", busy, mbusy);
         chk("rdy", in_ready,
             !mbusy && !sweep_start && !(out_valid && !out_ready));
         if (prev_stall) begin
            chk("hold_v", out_valid, 1);
            chk("hold_r", result, prev_r);
            chk("hold_f", flags, prev_f);
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("extra", 1, 0);
            end else begin
               e = q.pop_front();
               chk("res", result, e.r);
               chk("flg", flags, e.f);
               if (e.last) pend_done = 1;
            end
         end
         if (!mbusy && sweep_start) begin
            mbusy = 1;
            for (int i = 0; i < SL; i++) begin
               e = model(sweep_op, 8'(i), 8'(i));
               e.last = (i == SL - 1);
               q.push_back(e);
            end
         end else if (in_valid && in_ready) begin
            q.push_back(model(op, a, b));
         end
         if (dn) mbusy = 0;
         prev_stall = out_valid && !out_ready;
         prev_r = result;
         prev_f = flags;
      end
   end

   task automatic send(logic [2:0] o, logic [7:0] x, logic [7:0] y);
      in_valid = 1; op = o; a = x; b = y;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk); #1;
            in_valid = 0;
            return;
         end
      end
      chk("send_to", 0, 1);
      in_valid = 0;
      @(posedge clk); #1;
   endtask

   task automatic one(string tag, logic [2:0] o, logic [7:0] x,
                      logic [7:0] y, logic [7:0] er, logic [3:0] ef);
      send(o, x, y);
      chk({tag, "_v0"}, out_valid, 0);
      @(posedge clk); #1;
      chk({tag, "_v1"}, out_valid, 1);
      chk({tag, "_r"}, result, er);
      chk({tag, "_f"}, flags, ef);
      @(posedge clk); #1;
   endtask

   task automatic wait_done(string tag);
      bit seen = 0;
      for (int k = 0; k < 60 && !seen; k++) begin
         @(negedge clk);
         if (sweep_done) seen = 1;
      end
      chk(tag, seen, 1);
      @(posedge clk); #1;
   endtask

   function automatic logic [7:0] pick();
      case ($urandom_range(0, 7))
         0: return 8'h00;
         1: return 8'hFF;
         2: return 8'h7F;
         3: return 8'h80;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      #1;
      chk("rst_v", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", sweep_done, 0);
      chk("rst_r", result, 0);
      chk("rst_f", flags, 0);
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(posedge clk); #1;
      chk("idle_rdy", in_ready, 1);

      out_ready = 1;
      one("add", 3'd0, 8'd200, 8'd100, 8'd44, 4'b0100);
      one("sub", 3'd1, 8'd5, 8'd7, 8'hFE, 4'b0110);
      one("ovf", 3'd0, 8'h7F, 8'h01, 8'h80, 4'b1010);

      // Back-to-back ops into a stalled consumer
      out_ready = 0;
      send(3'd2, 8'hAA, 8'hAA);
      send(3'd7, 8'h00, 8'h00);
      repeat (3) begin
         @(posedge clk); #1;
         chk("stl_rdy", in_ready, 0);
         chk("stl_v", out_valid, 1);
         chk("stl_r", result, 8'h00);
         chk("stl_f", flags, 4'b0001);
      end
      out_ready = 1;
      @(posedge clk); #1;
      chk("rel_r", result, 8'hFF);
      chk("rel_f", flags, 4'b0010);
      repeat (3) @(posedge clk);
      #1;

      // Sweep wins over a same-cycle external op
      sweep_start = 1; sweep_op = 3'd0;
      in_valid = 1; op = 3'd2; a = 8'h11; b = 8'h22;
      @(posedge clk); #1;
      sweep_start = 0; in_valid = 0;
      chk("sw_busy", busy, 1);
      sweep_start = 1; sweep_op = 3'd7;
      @(posedge clk); #1;
      sweep_start = 0;
      wait_done("sw_done");
      chk("sw_idle", busy, 0);
      repeat (2) @(posedge clk);
      #1;

      // Reset in the middle of a sweep
      sweep_start = 1; sweep_op = 3'd1;
      @(posedge clk); #1;
      sweep_start = 0;
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1;
      #1;
      chk("ar_v", out_valid, 0);
      chk("ar_r", result, 0);
      chk("ar_f", flags, 0);
      chk("ar_busy", busy, 0);
      chk("ar_done", sweep_done, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      chk("ar_rdy", in_ready, 1);
      chk("ar_idle", busy, 0);
      @(posedge clk); #1;
      sweep_start = 1; sweep_op = 3'd0;
      @(posedge clk); #1;
      sweep_start = 0;
      wait_done("ar_sw_done");

      for (int n = 0; n < 400; n++) begin
         in_valid    = ($urandom_range(0, 9) < 6);
         op          = 3'($urandom_range(0, 7));
         a           = pick();
         b           = pick();
         out_ready   = ($urandom_range(0, 9) < 7);
         sweep_start = ($urandom_range(0, 49) == 0);
         sweep_op    = 3'($urandom_range(0, 7));
         @(posedge clk); #1;
      end
      in_valid = 0;
      sweep_start = 0;
      out_ready = 1;
      repeat (30) @(posedge clk);
      #1;
      chk("drain_q", q.size(), 0);
      chk("drain_busy", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
